disp_arbiter: RTL
=================

# disp_arbiter

Shares the 8-digit seven-segment display between two requesters: A (e.g. the counter value) and B (e.g. a status/message source). It grants ownership with a request/grant handshake and enforces a minimum hold time before preemption. It uses round-robin arbitration on contention. The owner's packed digit word is registered onto d0–d7, which feed disp_controller directly.

## Interface
- HOLD_CYCLES, default 100_000_000: minimum clk cycles an owner keeps the display before the other requester may preempt it (1 s at 100 MHz); legal range ≥ 1.
- clk  input  1  100 MHz system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- req_a  input  1  requester A wants the display; level, held while owning.
- data_a  input  32  A's digits packed: [3:0] → d0 … [31:28] → d7.
- req_b  input  1  requester B request, same rules as req_a.
- data_b  input  32  B's packed digits.
- gnt_a  output  1  A currently owns the display (registered).
- gnt_b  output  1  B currently owns the display (registered).
- d0..d7  output  4 each  registered hex digits to disp_controller d0..d7.

## Operation
- Internal registers: state ∈ {IDLE, OWN_A, OWN_B}; last_owner (A/B); hold_cnt, width $clog2(HOLD_CYCLES+1), saturating at 0.
- gnt_a = (state==OWN_A) and gnt_b = (state==OWN_B), both decoded from registered state. gnt_a and gnt_b are never high together.
- Reset: state=IDLE, gnt_a=gnt_b=0, d0..d7=0, hold_cnt=0, last_owner=B, so A wins the first contention.

IDLE transitions:
- Only req_a high → OWN_A.
- Only req_b high → OWN_B.
- Both high → the requester that is not last_owner.
- Neither high → stay in IDLE.
- On entering OWN_x: hold_cnt ← HOLD_CYCLES−1 and last_owner ← x.

OWN_x (y = the other requester):
- req_x=1, req_y=0 → stay. Capture d ← data_x. Decrement hold_cnt if nonzero.
- req_x=1, req_y=1, hold_cnt≠0 → stay, capture, decrement.
- req_x=1, req_y=1, hold_cnt==0 → go directly to OWN_y with no IDLE gap cycle. Reload hold_cnt. last_owner ← y. No capture on this edge.
- req_x=0, req_y=1 → go directly to OWN_y, reload hold_cnt, regardless of hold_cnt.
- req_x=0, req_y=0 → IDLE.

Digit register rules:
- d0..d7 load only on edges where state==OWN_x and req_x==1.
- Otherwise they retain their value, including in IDLE, so the last owner's digits stay on the display.
- Slicing: d_k = data_x[4k+3:4k]. No arithmetic or transformation is applied.

## Timing
- Grant latency: req rises before edge E0 in IDLE → gnt high after E0 (1 cycle).
- Data latency: first capture happens at E1, the edge after the grant rises, so d0..d7 show data_x after E1. After that, d tracks data_x with 1-cycle latency each cycle.
- Release latency: req_x falls before edge E → gnt_x low after E. If y was waiting, gnt_y goes high after the same edge E.
- Hold time: the owner granted at E0 can be preempted no earlier than edge E0+HOLD_CYCLES. With HOLD_CYCLES=1, preemption is possible at the first edge after the grant.
- Reset mid-ownership: at the reset edge all outputs return to reset values (d=0, gnts low) regardless of requests. Arbitration restarts from IDLE on the next edge.
- Reset asserted and a request present on the same edge: reset wins.

## Test plan
All scenarios run with HOLD_CYCLES=4.

- Reset values: assert reset 2 cycles with req_a=req_b=1 → gnt_a=gnt_b=0 and d0..d7=0 throughout. On the first edge after reset release, gnt_a=1 (A wins the first contention).
- Single owner: req_a=1, data_a=32'h7654_3210 → gnt_a high 1 cycle later; one cycle after that, d0=0, d1=1 … d7=7. Change data_a to 32'hFEDC_BA98 → d7..d0 = F..8 one cycle later.
- Hold and preemption: A owns; raise req_b=1 at 1 cycle after grant → gnt_a stays high until hold expires. gnt_b rises exactly 4 cycles after gnt_a rose, with no cycle where both grants are low. d then follows data_b=32'h1111_1111.
- Voluntary release with retention: A owns showing 32'h0000_00AB, then req_a drops with req_b=0 → gnt_a low next cycle, state IDLE, d0=B and d1=A retained indefinitely.
- Round-robin fairness: both requests held high continuously → grants alternate A, B, A, B with each ownership lasting exactly 4 cycles. The two grants are never high together.
- Reset mid-operation: assert reset while B owns with d nonzero → after the reset edge, d0..d7=0 and gnts low. After reset release with only req_b=1 → gnt_b after 1 cycle.

Source files
------------

// File: rtl/disp_arbiter.sv
// Arbitrates the 8-digit display between requesters A and B with a minimum
// hold time and round-robin tie breaking; the owner's digits are registered onto d0..d7.
module disp_arbiter #(
    parameter int unsigned HOLD_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic [31:0] data_a,
    input  logic        req_b,
    input  logic [31:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [3:0]  d4,
    output logic [3:0]  d5,
    output logic [3:0]  d6,
    output logic [3:0]  d7
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          last_b;
    logic [CW-1:0] hold_cnt;
    logic [31:0]   d_reg;
    logic          hold_done;
    logic          entering;
    logic          capture;
    logic          capture_b;

    assign hold_done = (hold_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    next_state = last_b ? OWN_A : OWN_B;
                end else if (req_a) begin
                    next_state = OWN_A;
                end else if (req_b) begin
                    next_state = OWN_B;
                end
            end
            OWN_A: begin
                if (req_a) begin
                    if (req_b && hold_done) begin
                        next_state = OWN_B;
                    end
                end else begin
                    next_state = req_b ? OWN_B : IDLE;
                end
            end
            OWN_B: begin
                if (req_b) begin
                    if (req_a && hold_done) begin
                        next_state = OWN_A;
                    end
                end else begin
                    next_state = req_a ? OWN_A : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Staying in an OWN state implies the owner still requests, so that alone gates capture.
    always_comb begin
        gnt_a     = (state == OWN_A);
        gnt_b     = (state == OWN_B);
        entering  = (next_state != state) && (next_state != IDLE);
        capture   = (next_state == state) && (state != IDLE);
        capture_b = (state == OWN_B);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            last_b   <= 1'b1;
            d_reg    <= '0;
        end else if (entering) begin
            hold_cnt <= RELOAD;
            last_b   <= (next_state == OWN_B);
        end else if (capture) begin
            d_reg <= capture_b ? data_b : data_a;
            if (!hold_done) begin
                hold_cnt <= hold_cnt - CW'(1);
            end
        end
    end

    assign d0 = d_reg[3:0];
    assign d1 = d_reg[7:4];
    assign d2 = d_reg[11:8];
    assign d3 = d_reg[15:12];
    assign d4 = d_reg[19:16];
    assign d5 = d_reg[23:20];
    assign d6 = d_reg[27:24];
    assign d7 = d_reg[31:28];

endmodule
